// File: rtl/hazard3_trigger_prog.sv
// Debug-Module sequencer that sets, clears or reads one breakpoint slot through the
// trigger unit's shared cfg port, saving and restoring tselect around the access.
// Build option: define HAZARD3_TRIGGER_PROG_VERIFY_EN to read back tdata1 after a set.
module hazard3_trigger_prog #(
  parameter int W_DATA              = 32,
  parameter int BREAKPOINT_TRIGGERS = 4,
  parameter int W_SLOT              = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_mode,
  input  logic [11:0]       csr_addr,
  input  logic              csr_wen,
  input  logic              csr_ren,
  input  logic [W_DATA-1:0] csr_wdata,
  output logic [W_DATA-1:0] csr_rdata,
  output logic              csr_stall,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [W_SLOT-1:0] req_slot,
  input  logic [W_DATA-1:0] req_addr,
  input  logic              req_action,
  input  logic              req_m,
  input  logic              req_u,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_err,
  output logic [W_DATA-1:0] rsp_tdata1,
  output logic [W_DATA-1:0] rsp_tdata2,
  output logic [11:0]       trig_cfg_addr,
  output logic              trig_cfg_wen,
  output logic [W_DATA-1:0] trig_cfg_wdata,
  input  logic [W_DATA-1:0] trig_cfg_rdata
);

  localparam logic [11:0] ADDR_TSELECT = 12'h7a0;
  localparam logic [11:0] ADDR_TDATA1  = 12'h7a1;
  localparam logic [11:0] ADDR_TDATA2  = 12'h7a2;

  localparam logic [1:0] OP_SET   = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [W_SLOT:0] N_TRIG = (W_SLOT+1)'(BREAKPOINT_TRIGGERS);

`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
  // Fields of tdata1 that the trigger unit must hold exactly as written.
  localparam logic [W_DATA-1:0] VERIFY_MASK = W_DATA'(32'h0800_104c);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_SEL,
    S_ACC_A,
    S_ACC_B,
    S_VERIFY,
    S_RESTORE,
    S_RESP
  } state_t;

  // mcontrol value for an execute breakpoint (type 2); action also selects dmode.
  function automatic logic [W_DATA-1:0] tdata1_for_set(input logic action, input logic m,
                                                       input logic u);
    logic [W_DATA-1:0] v;
    v        = '0;
    v[31:28] = 4'h2;
    v[27]    = action;
    v[12]    = action;
    v[6]     = m;
    v[3]     = u;
    v[2]     = 1'b1;
    return v;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [W_SLOT-1:0]   slot_q, slot_d;
  logic [W_DATA-1:0]   addr_q, addr_d;
  logic                action_q, action_d;
  logic                m_q, m_d;
  logic                u_q, u_d;
  logic [W_DATA-1:0]   tsel_q, tsel_d;
  logic                rsp_err_q, rsp_err_d;
  logic [W_DATA-1:0]   rsp_tdata1_q, rsp_tdata1_d;
  logic [W_DATA-1:0]   rsp_tdata2_q, rsp_tdata2_d;

  logic csr_access;
  logic seq_owns_port;
  logic req_bad;

  assign csr_access    = csr_wen | csr_ren;
  assign seq_owns_port = (state_q == S_SEL) || (state_q == S_ACC_A) || (state_q == S_ACC_B) ||
                         (state_q == S_VERIFY) || (state_q == S_RESTORE);
  assign req_bad       = (req_op == OP_RSVD) || ({1'b0, req_slot} >= N_TRIG) ||
                         ((req_op != OP_READ) && !d_mode);

  assign rsp_err    = rsp_err_q;
  assign rsp_tdata1 = rsp_tdata1_q;
  assign rsp_tdata2 = rsp_tdata2_q;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    slot_d         = slot_q;
    addr_d         = addr_q;
    action_d       = action_q;
    m_d            = m_q;
    u_d            = u_q;
    tsel_d         = tsel_q;
    rsp_err_d      = rsp_err_q;
    rsp_tdata1_d   = rsp_tdata1_q;
    rsp_tdata2_d   = rsp_tdata2_q;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    trig_cfg_addr  = csr_addr;
    trig_cfg_wen   = csr_wen;
    trig_cfg_wdata = csr_wdata;
    csr_rdata      = trig_cfg_rdata;
    csr_stall      = 1'b0;

    // While the sequencer owns the port, any CSR access is refused and must be retried.
    if (seq_owns_port) begin
      trig_cfg_addr  = ADDR_TSELECT;
      trig_cfg_wen   = 1'b0;
      trig_cfg_wdata = '0;
      csr_rdata      = '0;
      csr_stall      = csr_access;
    end

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d         = req_op;
          slot_d       = req_slot;
          addr_d       = req_addr;
          action_d     = req_action;
          m_d          = req_m;
          u_d          = req_u;
          rsp_tdata1_d = '0;
          rsp_tdata2_d = '0;
          rsp_err_d    = req_bad;
          state_d      = req_bad ? S_RESP : S_SAVE;
        end
      end
      S_SAVE: begin
        // The CSR block keeps the port this cycle; sample tselect on an idle cycle.
        if (!csr_access) begin
          trig_cfg_addr = ADDR_TSELECT;
          trig_cfg_wen  = 1'b0;
          tsel_d        = trig_cfg_rdata;
          state_d       = S_SEL;
        end
      end
      S_SEL: begin
        trig_cfg_wen   = 1'b1;
        trig_cfg_wdata = W_DATA'(slot_q);
        state_d        = S_ACC_A;
      end
      S_ACC_A: begin
        case (op_q)
          OP_SET: begin
            trig_cfg_addr  = ADDR_TDATA2;
            trig_cfg_wen   = 1'b1;
            trig_cfg_wdata = addr_q;
          end
          OP_CLEAR: begin
            trig_cfg_addr = ADDR_TDATA1;
            trig_cfg_wen  = 1'b1;
          end
          default: begin
            trig_cfg_addr = ADDR_TDATA1;
            rsp_tdata1_d  = trig_cfg_rdata;
          end
        endcase
        state_d = S_ACC_B;
      end
      S_ACC_B: begin
        // Set writes tdata2 before enabling via tdata1; clear disables via tdata1 first.
        case (op_q)
          OP_SET: begin
            trig_cfg_addr  = ADDR_TDATA1;
            trig_cfg_wen   = 1'b1;
            trig_cfg_wdata = tdata1_for_set(action_q, m_q, u_q);
          end
          OP_CLEAR: begin
            trig_cfg_addr = ADDR_TDATA2;
            trig_cfg_wen  = 1'b1;
          end
          default: begin
            trig_cfg_addr = ADDR_TDATA2;
            rsp_tdata2_d  = trig_cfg_rdata;
          end
        endcase
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
        state_d = (op_q == OP_SET) ? S_VERIFY : S_RESTORE;
`else
        state_d = S_RESTORE;
`endif
      end
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
      S_VERIFY: begin
        trig_cfg_addr = ADDR_TDATA1;
        if (((trig_cfg_rdata ^ tdata1_for_set(action_q, m_q, u_q)) & VERIFY_MASK) != '0) begin
          rsp_err_d = 1'b1;
        end
        state_d = S_RESTORE;
      end
`endif
      S_RESTORE: begin
        trig_cfg_wen   = 1'b1;
        trig_cfg_wdata = tsel_q;
        state_d        = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tsel_q       <= '0;
      rsp_err_q    <= 1'b0;
      rsp_tdata1_q <= '0;
      rsp_tdata2_q <= '0;
    end else begin
      state_q      <= state_d;
      tsel_q       <= tsel_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tdata1_q <= rsp_tdata1_d;
      rsp_tdata2_q <= rsp_tdata2_d;
    end
  end

  // Request fields are only consumed after an accept reloads them, so they need no reset.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    slot_q   <= slot_d;
    addr_q   <= addr_d;
    action_q <= action_d;
    m_q      <= m_d;
    u_q      <= u_d;
  end

endmodule

// File: tb/tb_hazard3_trigger_prog.sv
// Bench for hazard3_trigger_prog: a behavioural trigger unit sits on the cfg port and
// a slot-level reference model predicts responses, latencies and trigger contents.
module tb_hazard3_trigger_prog;

  localparam logic [11:0] A_TSEL = 12'h7a0;
  localparam logic [11:0] A_TD1  = 12'h7a1;
  localparam logic [11:0] A_TD2  = 12'h7a2;
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
  localparam int SET_LAT = 7;
`else
  localparam int SET_LAT = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_mode;
  logic [11:0] csr_addr;
  logic        csr_wen, csr_ren;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_stall;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_slot;
  logic [31:0] req_addr;
  logic        req_action, req_m, req_u;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_tdata1, rsp_tdata2;
  logic [11:0] trig_cfg_addr;
  logic        trig_cfg_wen;
  logic [31:0] trig_cfg_wdata, trig_cfg_rdata;

  always #5 clk = ~clk;

  hazard3_trigger_prog #(.W_DATA(32), .BREAKPOINT_TRIGGERS(4), .W_SLOT(4)) dut (
    .clk(clk), .rst_n(rst_n), .d_mode(d_mode),
    .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_stall(csr_stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_slot(req_slot),
    .req_addr(req_addr), .req_action(req_action), .req_m(req_m), .req_u(req_u),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_tdata1(rsp_tdata1), .rsp_tdata2(rsp_tdata2),
    .trig_cfg_addr(trig_cfg_addr), .trig_cfg_wen(trig_cfg_wen),
    .trig_cfg_wdata(trig_cfg_wdata), .trig_cfg_rdata(trig_cfg_rdata)
  );

  // Behavioural trigger unit: tselect plus four tdata1/tdata2 pairs, reset with rst_n.
  logic [31:0] tu_tsel;
  logic [31:0] tu_t1 [4];
  logic [31:0] tu_t2 [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tu_tsel <= 32'd0;
      for (int i = 0; i < 4; i++) begin
        tu_t1[i] <= 32'd0;
        tu_t2[i] <= 32'd0;
      end
    end else if (trig_cfg_wen) begin
      if (trig_cfg_addr == A_TSEL) tu_tsel <= trig_cfg_wdata;
      if (trig_cfg_addr == A_TD1 && tu_tsel < 32'd4) tu_t1[tu_tsel[1:0]] <= trig_cfg_wdata;
      if (trig_cfg_addr == A_TD2 && tu_tsel < 32'd4) tu_t2[tu_tsel[1:0]] <= trig_cfg_wdata;
    end
  end

  always_comb begin
    trig_cfg_rdata = 32'd0;
    if (trig_cfg_addr == A_TSEL) trig_cfg_rdata = tu_tsel;
    if (trig_cfg_addr == A_TD1 && tu_tsel < 32'd4) trig_cfg_rdata = tu_t1[tu_tsel[1:0]];
    if (trig_cfg_addr == A_TD2 && tu_tsel < 32'd4) trig_cfg_rdata = tu_t2[tu_tsel[1:0]];
  end

  logic [43:0] wlog [$];
  always @(posedge clk) begin
    if (rst_n && trig_cfg_wen) wlog.push_back({trig_cfg_addr, trig_cfg_wdata});
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] ref_t1 [4];
  logic [31:0] ref_t2 [4];
  logic [31:0] ref_tsel;

  function automatic logic [31:0] set_value(input logic act, input logic m, input logic u);
    return 32'h2000_0000 + (act ? 32'h0800_1000 : 32'd0) + (m ? 32'h40 : 32'd0) +
           (u ? 32'h8 : 32'd0) + 32'h4;
  endfunction

  task automatic reset_ref();
    for (int i = 0; i < 4; i++) begin
      ref_t1[i] = 32'd0;
      ref_t2[i] = 32'd0;
    end
    ref_tsel = 32'd0;
  endtask

  task automatic check_tu(input string tag);
    check({tag, "_tsel"}, tu_tsel, ref_tsel);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_t1[%0d]", tag, i), tu_t1[i], ref_t1[i]);
      check($sformatf("%s_t2[%0d]", tag, i), tu_t2[i], ref_t2[i]);
    end
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_addr = a; csr_wdata = d; csr_wen = 1'b1;
    @(negedge clk);
    csr_wen = 1'b0;
  endtask

  // Issue one request, wait (bounded) for the response and return latency and fields.
  task automatic do_req(input logic [1:0] op, input logic [3:0] slot, input logic [31:0] a,
                        input logic act, input logic m, input logic u, input logic dm,
                        output int lat, output logic err, output logic [31:0] t1,
                        output logic [31:0] t2);
    @(negedge clk);
    d_mode = dm; req_op = op; req_slot = slot; req_addr = a;
    req_action = act; req_m = m; req_u = u; req_valid = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    err = rsp_err; t1 = rsp_tdata1; t2 = rsp_tdata2;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int          lat;
  logic        err;
  logic [31:0] t1, t2;
  logic [1:0]  r_op;
  int          r_slot;
  logic [31:0] r_addr, r_pre;
  logic        r_act, r_m, r_u, r_dm, exp_err;
  logic [31:0] exp_t1, exp_t2;
  int          exp_lat;

  initial begin
    rst_n = 1'b0; d_mode = 1'b0; csr_addr = 12'd0; csr_wen = 1'b0; csr_ren = 1'b0;
    csr_wdata = 32'd0; req_valid = 1'b0; req_op = 2'd0; req_slot = 4'd0; req_addr = 32'd0;
    req_action = 1'b0; req_m = 1'b0; req_u = 1'b0; rsp_ready = 1'b0;
    reset_ref();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_tdata1", rsp_tdata1, 32'd0);
    check("rst_rsp_tdata2", rsp_tdata2, 32'd0);
    check("rst_csr_stall", {31'd0, csr_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed set of slot 1 with tselect previously 3.
    csr_write(A_TSEL, 32'd3);
    ref_tsel = 32'd3;
    do_req(2'd0, 4'd1, 32'h0000_1234, 1'b1, 1'b1, 1'b0, 1'b1, lat, err, t1, t2);
    check("set1_lat", lat, SET_LAT);
    check("set1_err", {31'd0, err}, 32'd0);
    ref_t1[1] = 32'h2800_1044;
    ref_t2[1] = 32'h0000_1234;
    check_tu("set1");
    @(negedge clk);
    csr_addr = A_TSEL; csr_ren = 1'b1;
    #1;
    check("set1_csr_tsel_rd", csr_rdata, 32'd3);
    csr_ren = 1'b0;

    // Directed read back of slot 1.
    do_req(2'd2, 4'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, lat, err, t1, t2);
    check("rd1_lat", lat, 6);
    check("rd1_err", {31'd0, err}, 32'd0);
    check("rd1_t1", t1, 32'h2800_1044);
    check("rd1_t2", t2, 32'h0000_1234);
    check("rd1_tsel", tu_tsel, 32'd3);

    // Rejected requests: slot out of range, and a set outside Debug mode.
    wlog.delete();
    do_req(2'd0, 4'd4, 32'h55, 1'b1, 1'b1, 1'b1, 1'b1, lat, err, t1, t2);
    check("bad_slot_lat_le2", {31'd0, (lat >= 1 && lat <= 2)}, 32'd1);
    check("bad_slot_err", {31'd0, err}, 32'd1);
    do_req(2'd0, 4'd1, 32'h66, 1'b1, 1'b1, 1'b1, 1'b0, lat, err, t1, t2);
    check("no_dmode_lat_le2", {31'd0, (lat >= 1 && lat <= 2)}, 32'd1);
    check("no_dmode_err", {31'd0, err}, 32'd1);
    check("bad_no_writes", wlog.size(), 32'd0);
    check_tu("bad");

    // CSR contention: reads hold SAVE for 3 cycles, then a write during SEL is stalled.
    @(negedge clk);
    d_mode = 1'b1; req_op = 2'd0; req_slot = 4'd2; req_addr = 32'hcafe_0000;
    req_action = 1'b0; req_m = 1'b1; req_u = 1'b1; req_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req_valid = 1'b0; csr_ren = 1'b1; csr_addr = A_TD2;
      #1;
      check($sformatf("save_stall_c%0d", c), {31'd0, csr_stall}, 32'd0);
      check($sformatf("save_pass_rd_c%0d", c), csr_rdata, ref_t2[3]);
    end
    @(negedge clk);
    csr_ren = 1'b0;
    #1;
    check("save_seq_wen", {31'd0, trig_cfg_wen}, 32'd0);
    check("save_seq_addr", {20'd0, trig_cfg_addr}, {20'd0, A_TSEL});
    @(negedge clk);
    csr_wen = 1'b1; csr_addr = A_TSEL; csr_wdata = 32'd2;
    #1;
    check("sel_csr_stall", {31'd0, csr_stall}, 32'd1);
    check("sel_csr_rdata", csr_rdata, 32'd0);
    lat = -1;
    for (int c = 6; c <= 40; c++) begin
      @(negedge clk);
      csr_wen = 1'b0;
      #1;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    check("cont_lat", lat, SET_LAT + 3);
    check("cont_err", {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ref_t1[2] = set_value(1'b0, 1'b1, 1'b1);
    ref_t2[2] = 32'hcafe_0000;
    check_tu("cont");

    // Clear slot 0 with a held response, then check write order.
    wlog.delete();
    @(negedge clk);
    d_mode = 1'b1; req_op = 2'd1; req_slot = 4'd0; req_valid = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    check("clr_lat", lat, 6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("clr_hold_%0d", k), {31'd0, rsp_valid}, 32'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("clr_valid_with_ready", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("clr_valid_dropped", {31'd0, rsp_valid}, 32'd0);
    check("clr_nwrites", wlog.size(), 32'd4);
    if (wlog.size() == 4) begin
      check("clr_w0_tsel", {20'd0, wlog[0][43:32]}, {20'd0, A_TSEL});
      check("clr_w1_td1", {20'd0, wlog[1][43:32]}, {20'd0, A_TD1});
      check("clr_w1_data", wlog[1][31:0], 32'd0);
      check("clr_w2_td2", {20'd0, wlog[2][43:32]}, {20'd0, A_TD2});
      check("clr_w2_data", wlog[2][31:0], 32'd0);
      check("clr_w3_restore", wlog[3][31:0], ref_tsel);
    end

    // Randomised requests against the slot-level model.
    for (int it = 0; it < 40; it++) begin
      r_op = 2'($urandom_range(0, 3));
      r_slot = $urandom_range(0, 5);
      r_dm = ($urandom_range(0, 3) != 0);
      r_addr = $urandom;
      r_act = 1'($urandom_range(0, 1));
      r_m = 1'($urandom_range(0, 1));
      r_u = 1'($urandom_range(0, 1));
      r_pre = 32'($urandom_range(0, 7));
      csr_write(A_TSEL, r_pre);
      ref_tsel = r_pre;
      exp_err = (r_op == 2'd3) || (r_slot >= 4) || (r_op != 2'd2 && !r_dm);
      exp_t1 = 32'd0;
      exp_t2 = 32'd0;
      exp_lat = 6;
      if (!exp_err) begin
        if (r_op == 2'd0) begin
          ref_t1[r_slot] = set_value(r_act, r_m, r_u);
          ref_t2[r_slot] = r_addr;
          exp_lat = SET_LAT;
        end else if (r_op == 2'd1) begin
          ref_t1[r_slot] = 32'd0;
          ref_t2[r_slot] = 32'd0;
        end else begin
          exp_t1 = ref_t1[r_slot];
          exp_t2 = ref_t2[r_slot];
        end
      end
      wlog.delete();
      do_req(r_op, 4'(r_slot), r_addr, r_act, r_m, r_u, r_dm, lat, err, t1, t2);
      if (exp_err) begin
        check($sformatf("rnd%0d_err_lat", it), {31'd0, (lat >= 1 && lat <= 2)}, 32'd1);
        check($sformatf("rnd%0d_err_nwr", it), wlog.size(), 32'd0);
      end else begin
        check($sformatf("rnd%0d_lat", it), lat, exp_lat);
      end
      check($sformatf("rnd%0d_err", it), {31'd0, err}, {31'd0, exp_err});
      check($sformatf("rnd%0d_t1", it), t1, exp_t1);
      check($sformatf("rnd%0d_t2", it), t2, exp_t2);
      check_tu($sformatf("rnd%0d", it));
    end

    // Reset during ACC_A abandons the sequence.
    @(negedge clk);
    d_mode = 1'b1; req_op = 2'd0; req_slot = 4'd3; req_addr = 32'h1111_2222;
    req_action = 1'b1; req_m = 1'b0; req_u = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    reset_ref();
    #1;
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("mid_rst_rsp_t1", rsp_tdata1, 32'd0);
    check("mid_rst_rsp_t2", rsp_tdata2, 32'd0);
    check("mid_rst_stall", {31'd0, csr_stall}, 32'd0);
    check("mid_rst_wen", {31'd0, trig_cfg_wen}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_tu("post_rst");
    do_req(2'd2, 4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, lat, err, t1, t2);
    check("post_rst_rd_lat", lat, 6);
    check("post_rst_rd_t1", t1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
